// File: rtl/rbus_arb_rr_if.sv
// rbus arbiter bundle: N requester lanes in, one shared rbus channel out.
// The arbiter uses the slave modport; requesters plus the sink use master.
interface rbus_arb_rr_if #(
  parameter int unsigned N = 4
) ();
  logic [1:0]   i_req  [N];
  logic [N-1:0] i_gnt;
  logic [N-1:0] i_stb;
  logic [N-1:0] i_sof;
  logic [71:0]  i_data [N];
  logic         o_stb;
  logic         o_sof;
  logic [71:0]  o_data;
  logic         o_lane;
  logic [1:0]   o_rdy;
  logic         o_tmo;
  logic         ff_err;

  modport slave (
    input  i_req, i_stb, i_sof, i_data, o_rdy,
    output i_gnt, o_stb, o_sof, o_data, o_lane, o_tmo, ff_err
  );

  modport master (
    output i_req, i_stb, i_sof, i_data, o_rdy,
    input  i_gnt, o_stb, o_sof, o_data, o_lane, o_tmo, ff_err
  );
endinterface

// File: rtl/rbus_arb_rr.sv
// Packet-level round-robin arbiter for a shared rbus link. Lane 1 outranks
// lane 0; within a lane a single shared pointer rotates the winner. One packet
// is granted at a time and forwarded through a one-cycle registered datapath.
module rbus_arb_rr #(
  parameter int unsigned N   = 4,
  parameter int unsigned TMO = 15
) (
  input logic          clk,
  input logic          rst,
  rbus_arb_rr_if.slave bus_io
);

  localparam int unsigned PtrW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]  TmoCnt = 8'(TMO);

  typedef enum logic [1:0] {StIdle, StWaitSof, StXfer} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            lane_q, lane_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            o_stb_q, o_stb_d;
  logic            o_sof_q, o_sof_d;
  logic [71:0]     o_data_q, o_data_d;
  logic            o_tmo_q, o_tmo_d;
  logic            err_q, err_d;

  logic [N-1:0]    elig0, elig1, elig;
  logic            lane_pick;
  logic            found;
  logic [PtrW-1:0] win;
  logic            g_stb, g_sof;
  logic [71:0]     g_data;
  logic            stray;

  // Eligibility per lane, lane choice, and round-robin pick from last_winner+1.
  always_comb begin
    int unsigned c;
    logic [PtrW-1:0] cp;
    c     = 0;
    cp    = '0;
    elig0 = '0;
    elig1 = '0;
    for (int unsigned n = 0; n < N; n++) begin
      elig0[n] = bus_io.i_req[n][0] & bus_io.o_rdy[0];
      elig1[n] = bus_io.i_req[n][1] & bus_io.o_rdy[1];
    end
    lane_pick = |elig1;
    elig      = lane_pick ? elig1 : elig0;
    found     = 1'b0;
    win       = ptr_q;
    for (int unsigned i = 1; i <= N; i++) begin
      c  = (32'(ptr_q) + i) % N;
      cp = PtrW'(c);
      if (!found && elig[cp]) begin
        found = 1'b1;
        win   = cp;
      end
    end
  end

  // Granted channel's inputs; ptr_q doubles as the current winner's index.
  // In IDLE gnt_q is zero, so any strobe there counts as stray.
  always_comb begin
    g_stb  = bus_io.i_stb[ptr_q] & gnt_q[ptr_q];
    g_sof  = bus_io.i_sof[ptr_q];
    g_data = bus_io.i_data[ptr_q];
    stray  = |(bus_io.i_stb & ~gnt_q);
  end

  // FSM next state, grant bookkeeping, timeout and forwarded word.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    o_stb_d  = 1'b0;
    o_sof_d  = 1'b0;
    o_data_d = o_data_q;
    o_tmo_d  = 1'b0;
    err_d    = err_q | stray;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          ptr_d      = win;
          lane_d     = lane_pick;
          cnt_d      = '0;
          state_d    = StWaitSof;
        end
      end
      StWaitSof: begin
        if (g_stb && g_sof) begin
          // A sof on the timeout cycle wins over the timeout.
          o_stb_d  = 1'b1;
          o_sof_d  = 1'b1;
          o_data_d = g_data;
          state_d  = StXfer;
        end else begin
          if (g_stb) begin
            err_d = 1'b1;
          end
          if (cnt_q >= TmoCnt) begin
            gnt_d   = '0;
            o_tmo_d = 1'b1;
            state_d = StIdle;
          end else if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StXfer: begin
        if (g_stb) begin
          o_stb_d  = 1'b1;
          o_sof_d  = g_sof;
          o_data_d = g_data;
          if (g_sof) begin
            err_d = 1'b1;
          end
        end else begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      ptr_q    <= PtrW'(N - 1);
      lane_q   <= 1'b0;
      cnt_q    <= '0;
      o_stb_q  <= 1'b0;
      o_sof_q  <= 1'b0;
      o_data_q <= '0;
      o_tmo_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      o_stb_q  <= o_stb_d;
      o_sof_q  <= o_sof_d;
      o_data_q <= o_data_d;
      o_tmo_q  <= o_tmo_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.i_gnt  = gnt_q;
  assign bus_io.o_stb  = o_stb_q;
  assign bus_io.o_sof  = o_sof_q;
  assign bus_io.o_data = o_data_q;
  assign bus_io.o_lane = lane_q;
  assign bus_io.o_tmo  = o_tmo_q;
  assign bus_io.ff_err = err_q;

endmodule
